// File: rtl/mioc_dram_seq_pkg.sv
// Shared MIOC DRAM definitions: sequencer states, watchdog default, bank and strobe polarities.
package mioc_dram_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_COL  = 3'd2,
        ST_CAS  = 3'd3,
        ST_REF  = 3'd4,
        ST_PRE  = 3'd5
    } dram_state_t;

    localparam int   WDOG_MAX_DEF = 15;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;
    localparam logic BANK0      = 1'b0;
    localparam logic BANK1      = 1'b1;
    localparam logic MUX_ROW    = 1'b0;
    localparam logic MUX_COL    = 1'b1;

endpackage

// File: rtl/mioc_dram_seq_rfsh_cnt.sv
// 8-bit wrapping refresh counter; bit 7 extends the Z80's 7-bit refresh row.
module mioc_rfsh_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_en,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= 8'd0;
        else if (inc_en)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/mioc_dram_seq.sv
// DRAM cycle sequencer: turns sampled Z80 bus strobes into RAS/MUX/CAS timing,
// muxes RA7 and guards RAS low time with a watchdog.
module mioc_dram_seq
    import mioc_dram_seq_pkg::*;
#(
    parameter int WDOG_MAX = WDOG_MAX_DEF
) (
    input  logic       B_PHI,
    input  logic       RST_N,
    input  logic       BMREQ_N,
    input  logic       BRFSH_N,
    input  logic       BRD_N,
    input  logic       N_BWR,
    input  logic       BA7,
    input  logic       BA15,
    input  logic       ram_en,
    output logic       RAS_N,
    output logic       MUX,
    output logic       CAS1_N,
    output logic       CAS2_N,
    output logic       RA7,
    output logic [7:0] rfsh_cnt,
    output logic       wdog_err
);

    dram_state_t state, state_nxt;
    logic        bank, bank_nxt;
    logic [3:0]  wdog;
    logic        active, active_nxt, wdog_hit, rfsh_inc;
    logic        req_ref, req_mem, release_req;

    always_comb begin
        active      = state inside {ST_ROW, ST_COL, ST_CAS, ST_REF};
        wdog_hit    = active && (wdog == 4'(WDOG_MAX - 1));
        release_req = BMREQ_N || wdog_hit;
        req_ref     = !BMREQ_N && !BRFSH_N;
        req_mem     = !BMREQ_N && BRFSH_N && ram_en && (!BRD_N || !N_BWR);
        state_nxt   = state;
        bank_nxt    = bank;
        case (state)
            ST_IDLE: begin
                if (req_ref) begin
                    state_nxt = ST_REF;
                end else if (req_mem) begin
                    state_nxt = ST_ROW;
                    bank_nxt  = BA15;
                end
            end
            ST_ROW:  state_nxt = release_req ? ST_PRE : ST_COL;
            ST_COL:  state_nxt = release_req ? ST_PRE : ST_CAS;
            ST_CAS,
            ST_REF:  if (release_req) state_nxt = ST_PRE;
            ST_PRE:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        active_nxt = state_nxt inside {ST_ROW, ST_COL, ST_CAS, ST_REF};
        // Any exit from REF counts, including one forced by the watchdog.
        rfsh_inc   = (state == ST_REF) && (state_nxt == ST_PRE);
    end

    // Strobes are registered from the next state, so they equal a decode of state.
    always_ff @(posedge B_PHI) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            bank     <= BANK0;
            wdog     <= 4'd0;
            wdog_err <= 1'b0;
            RAS_N    <= STROBE_OFF;
            MUX      <= MUX_ROW;
            CAS1_N   <= STROBE_OFF;
            CAS2_N   <= STROBE_OFF;
        end else begin
            state  <= state_nxt;
            bank   <= bank_nxt;
            wdog   <= (active && active_nxt) ? wdog + 4'd1 : 4'd0;
            if (wdog_hit && !BMREQ_N)
                wdog_err <= 1'b1;
            RAS_N  <= active_nxt ? STROBE_ON : STROBE_OFF;
            MUX    <= (state_nxt inside {ST_COL, ST_CAS}) ? MUX_COL : MUX_ROW;
            CAS1_N <= (state_nxt == ST_CAS && bank_nxt == BANK0) ? STROBE_ON : STROBE_OFF;
            CAS2_N <= (state_nxt == ST_CAS && bank_nxt == BANK1) ? STROBE_ON : STROBE_OFF;
        end
    end

    always_comb begin
        case (state)
            ST_ROW:         RA7 = BA7;
            ST_COL, ST_CAS: RA7 = bank;
            ST_REF:         RA7 = rfsh_cnt[7];
            default:        RA7 = 1'b0;
        endcase
    end

    mioc_rfsh_cnt u_rfsh_cnt (
        .clk    (B_PHI),
        .rst_n  (RST_N),
        .inc_en (rfsh_inc),
        .count  (rfsh_cnt)
    );

endmodule

// File: tb/tb_mioc_dram_seq.sv
// Scoreboard bench for mioc_dram_seq: expected pin snapshots queued per cycle, compared after each edge.
module tb_mioc_dram_seq;

    logic       b_phi = 1'b0;
    logic       rst_n, bmreq_n, brfsh_n, brd_n, bwr_n, ba7, ba15, ram_en;
    logic       ras_n, mux, cas1_n, cas2_n, ra7, wdog_err;
    logic [7:0] rfsh_cnt;

    int nerr = 0;
    int nchk = 0;

    logic [13:0] exp_q[$];
    string       tag_q[$];

    mioc_dram_seq dut (
        .B_PHI    (b_phi),
        .RST_N    (rst_n),
        .BMREQ_N  (bmreq_n),
        .BRFSH_N  (brfsh_n),
        .BRD_N    (brd_n),
        .N_BWR    (bwr_n),
        .BA7      (ba7),
        .BA15     (ba15),
        .ram_en   (ram_en),
        .RAS_N    (ras_n),
        .MUX      (mux),
        .CAS1_N   (cas1_n),
        .CAS2_N   (cas2_n),
        .RA7      (ra7),
        .rfsh_cnt (rfsh_cnt),
        .wdog_err (wdog_err)
    );

    always #5 b_phi = ~b_phi;

    function automatic logic [13:0] ev(input logic ras, input logic mx, input logic c1,
                                       input logic c2, input logic r7, input logic [7:0] cnt,
                                       input logic we);
        return {ras, mx, c1, c2, r7, cnt, we};
    endfunction

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got ras/mux/c1/c2/ra7=%b cnt=%h werr=%b, want %b cnt=%h werr=%b",
                     tag, got[13:9], got[8:1], got[0], exp[13:9], exp[8:1], exp[0]);
        end
    endtask

    // Inputs are set just before calling; the edge follows, then the snapshot is checked.
    task automatic step(input string tag, input logic [13:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge b_phi);
        #1;
        chk(tag_q.pop_front(), {ras_n, mux, cas1_n, cas2_n, ra7, rfsh_cnt, wdog_err},
            exp_q.pop_front());
        @(negedge b_phi);
    endtask

    task automatic bus(input logic bm, input logic rf, input logic rd, input logic wr);
        bmreq_n = bm; brfsh_n = rf; brd_n = rd; bwr_n = wr;
    endtask

    task automatic refresh(input int i, input logic we);
        logic [7:0] c, c1;
        c  = 8'(i);
        c1 = 8'(i + 1);
        bus(0, 0, 1, 1);
        step("ref", ev(0, 0, 1, 1, c[7], c, we));
        bus(1, 1, 1, 1);
        step("ref_pre", ev(1, 0, 1, 1, 0, c1, we));
        step("ref_idle", ev(1, 0, 1, 1, 0, c1, we));
    endtask

    initial begin
        rst_n = 0; ba7 = 0; ba15 = 0; ram_en = 0;
        bus(1, 1, 1, 1);
        @(negedge b_phi);
        step("reset", ev(1, 0, 1, 1, 0, 8'h00, 0));
        rst_n = 1;

        // Full 256-row refresh sweep, counter wraps back to 0
        for (int i = 0; i < 256; i++) refresh(i, 0);
        step("rfsh_wrap", ev(1, 0, 1, 1, 0, 8'h00, 0));

        // Read, bank 0, RA7 follows BA7 in ROW then latched bank
        ram_en = 1; ba15 = 0; ba7 = 1;
        bus(0, 1, 0, 1);
        step("rd_row", ev(0, 0, 1, 1, 1, 8'h00, 0));
        step("rd_col", ev(0, 1, 1, 1, 0, 8'h00, 0));
        step("rd_cas", ev(0, 1, 0, 1, 0, 8'h00, 0));
        step("rd_cas2", ev(0, 1, 0, 1, 0, 8'h00, 0));
        bus(1, 1, 1, 1);
        step("rd_pre", ev(1, 0, 1, 1, 0, 8'h00, 0));
        step("rd_idle", ev(1, 0, 1, 1, 0, 8'h00, 0));

        // Write, bank 1, BA15 wiggled mid-cycle
        ba15 = 1; ba7 = 0;
        bus(0, 1, 1, 0);
        step("wr_row", ev(0, 0, 1, 1, 0, 8'h00, 0));
        ba15 = 0;
        step("wr_col", ev(0, 1, 1, 1, 1, 8'h00, 0));
        ba15 = 1;
        step("wr_cas", ev(0, 1, 1, 0, 1, 8'h00, 0));
        ba15 = 0;
        step("wr_cas2", ev(0, 1, 1, 0, 1, 8'h00, 0));
        bus(1, 1, 1, 1);
        step("wr_pre", ev(1, 0, 1, 1, 0, 8'h00, 0));
        step("wr_idle", ev(1, 0, 1, 1, 0, 8'h00, 0));

        // Abort during ROW: never reaches CAS
        bus(0, 1, 0, 1);
        step("ab_row", ev(0, 0, 1, 1, 0, 8'h00, 0));
        bus(1, 1, 1, 1);
        step("ab_pre", ev(1, 0, 1, 1, 0, 8'h00, 0));
        step("ab_idle", ev(1, 0, 1, 1, 0, 8'h00, 0));
        step("ab_idle2", ev(1, 0, 1, 1, 0, 8'h00, 0));

        // Request outside DRAM map
        ram_en = 0;
        bus(0, 1, 0, 1);
        step("noram1", ev(1, 0, 1, 1, 0, 8'h00, 0));
        step("noram2", ev(1, 0, 1, 1, 0, 8'h00, 0));
        bus(1, 1, 1, 1);
        step("noram_idle", ev(1, 0, 1, 1, 0, 8'h00, 0));

        // Stuck refresh: forced PRE after 15 RAS cycles, then a new refresh starts
        bus(0, 0, 1, 1);
        for (int i = 1; i <= 20; i++) begin
            if (i <= 15)      step("wd_ref", ev(0, 0, 1, 1, 0, 8'h00, 0));
            else if (i == 16) step("wd_pre", ev(1, 0, 1, 1, 0, 8'h01, 1));
            else if (i == 17) step("wd_idle", ev(1, 0, 1, 1, 0, 8'h01, 1));
            else              step("wd_ref2", ev(0, 0, 1, 1, 0, 8'h01, 1));
        end
        bus(1, 1, 1, 1);
        step("wd_rel_pre", ev(1, 0, 1, 1, 0, 8'h02, 1));
        step("wd_rel_idle", ev(1, 0, 1, 1, 0, 8'h02, 1));

        // Reset clears sticky error and counter
        rst_n = 0;
        step("rst2", ev(1, 0, 1, 1, 0, 8'h00, 0));
        rst_n = 1;
        for (int i = 0; i < 127; i++) refresh(i, 0);

        // Reset landing in CAS with rfsh_cnt = 0x7F
        ram_en = 1; ba15 = 1; ba7 = 1;
        bus(0, 1, 0, 1);
        step("rc_row", ev(0, 0, 1, 1, 1, 8'h7F, 0));
        step("rc_col", ev(0, 1, 1, 1, 1, 8'h7F, 0));
        step("rc_cas", ev(0, 1, 1, 0, 1, 8'h7F, 0));
        rst_n = 0;
        step("rc_reset", ev(1, 0, 1, 1, 0, 8'h00, 0));
        rst_n = 1;
        bus(1, 1, 1, 1);
        step("rc_idle", ev(1, 0, 1, 1, 0, 8'h00, 0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
